unidad_multdiv: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, placed beside the combinational N-bit ALU. The ALU resolves add/sub/logic/shift in one cycle. This block handles the instructions the ALU cannot: MULT, MULTU, DIV and DIVU. It computes one result bit per clock and writes the HI/LO register pair. The control unit starts it with a single-pulse handshake and stalls until `done_o`.

---
 rtl/unidad_multdiv.sv | 183 ++++++++++++++++++
 tb/tb_unidad_multdiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_multdiv.sv
// unidad_multdiv: iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
// Latency: N+1 cycles from the accepting edge to done_o (1 cycle for divide by zero).
// Backpressure: start_i is only sampled in IDLE; requests while busy are dropped.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   a_i, b_i              operands (multiplicand/dividend, multiplier/divisor)
//   operacion_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start_i               request, one pulse
//   busy_o, done_o        busy window / one-cycle completion pulse
//   hi_o, lo_o            product high/low, or remainder/quotient
//   divzero_o, zeroflag_o last division had divisor 0 / LO is zero
//
// Build option: define MULTDIV_DIV_EN to include the divider. Without it,
// division codes complete immediately with HI = LO = 0 and divzero_o = 0.
module unidad_multdiv #(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [1:0]   operacion_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] hi_o,
   output logic [N-1:0] lo_o,
   output logic         divzero_o,
   output logic         zeroflag_o
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] acc;       // {upper half, lower half} working register
   logic [N-1:0]   opb;       // |B|: multiplicand addend or divisor
   logic           is_div_q;
   logic           neg_q;     // negate product / quotient in FIX

   // Request decode
   logic           signed_op;
   logic           is_div;
   logic           skip_calc;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;

   assign signed_op = ~operacion_i[0];
   assign is_div    = operacion_i[1];
   assign a_mag     = (signed_op & a_i[N-1]) ? -a_i : a_i;
   assign b_mag     = (signed_op & b_i[N-1]) ? -b_i : b_i;

   // Shift-add multiply step: add |B| into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right (carry in).
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opb : {N{1'b0}})};
   assign mul_next = {mul_sum, acc[N-1:1]};

   logic [2*N-1:0] step_next;
   logic [2*N-1:0] fix_res;

`ifdef MULTDIV_DIV_EN
   logic           dz;        // divisor was zero: acc already holds the answer
   logic           neg_r;     // remainder takes the dividend's sign

   // Restoring divide step: bring the next dividend bit into the partial
   // remainder (N+1 bits wide so the trial compare cannot overflow).
   logic [N:0]     trial;
   logic [N-1:0]   rem_sub;
   logic           ge;
   logic [2*N-1:0] div_next;

   assign trial    = {acc[2*N-1:N], acc[N-1]};
   assign ge       = trial >= {1'b0, opb};
   // When ge, the true difference is below opb and fits in N bits.
   assign rem_sub  = trial[N-1:0] - opb;
   assign div_next = {(ge ? rem_sub : trial[N-1:0]), acc[N-2:0], ge};

   assign skip_calc = is_div & (b_i == {N{1'b0}});
   assign step_next = is_div_q ? div_next : mul_next;

   always_comb begin
      fix_res = neg_q ? -acc : acc;
      if (is_div_q) begin
         if (dz) begin
            fix_res = acc;
         end else begin
            fix_res = {(neg_r ? -acc[2*N-1:N] : acc[2*N-1:N]),
                       (neg_q ? -acc[N-1:0]   : acc[N-1:0])};
         end
      end
   end
`else
   assign skip_calc = is_div;
   assign step_next = mul_next;
   // Division requests leave acc cleared, so only the multiply fixup matters.
   assign fix_res   = (neg_q & ~is_div_q) ? -acc : acc;
   assign divzero_o = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = skip_calc ? FIX : CALC;
         CALC:    if (cnt == CW'(N - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt       <= '0;
         acc       <= '0;
         opb       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         hi_o      <= '0;
         lo_o      <= '0;
`ifdef MULTDIV_DIV_EN
         dz        <= 1'b0;
         neg_r     <= 1'b0;
         divzero_o <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               // Also clears busy_o after the done_o cycle when nothing follows.
               busy_o <= start_i;
               if (start_i) begin
                  cnt      <= '0;
                  opb      <= b_mag;
                  is_div_q <= is_div;
                  neg_q    <= signed_op & (a_i[N-1] ^ b_i[N-1]);
                  acc      <= {{N{1'b0}}, a_mag};
`ifdef MULTDIV_DIV_EN
                  neg_r     <= signed_op & a_i[N-1];
                  dz        <= skip_calc;
                  divzero_o <= 1'b0;
                  // Divide by zero: HI = raw dividend, LO = all ones.
                  if (skip_calc) acc <= {a_i, {N{1'b1}}};
`else
                  if (is_div) acc <= '0;
`endif
               end
            end
            CALC: begin
               acc <= step_next;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               {hi_o, lo_o} <= fix_res;
               done_o       <= 1'b1;
`ifdef MULTDIV_DIV_EN
               divzero_o    <= dz;
`endif
            end
            default: ;
         endcase
      end
   end

   assign zeroflag_o = ~|lo_o;

endmodule

// File: tb/tb_unidad_multdiv.sv
module tb_unidad_multdiv;

   localparam int N = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [N-1:0]  a_i;
   logic [N-1:0]  b_i;
   logic [1:0]    operacion_i;
   logic          start_i;
   logic          busy_o;
   logic          done_o;
   logic [N-1:0]  hi_o;
   logic [N-1:0]  lo_o;
   logic          divzero_o;
   logic          zeroflag_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   unidad_multdiv #(.N(N)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .operacion_i (operacion_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .divzero_o   (divzero_o),
      .zeroflag_o  (zeroflag_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Presents a request for the next edge (edge 0), then
   // scrambles the operands so a late sample would be visible.
   task automatic launch(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold);
      operacion_i = op;
      a_i         = a;
      b_i         = b;
      start_i     = 1'b1;
      @(posedge clk_i);
      #1;
      if (!hold) start_i = 1'b0;
      a_i         = ~a;
      b_i         = ~b;
      operacion_i = ~op;
   endtask

   // k = number of edges since the accepting edge, sampled at negedges.
   // pa > 0 pulses start_i at edges pa and 2*pa while busy.
   task automatic wait_done(input string tag, input int exp_lat, input int pa);
      int k = 0;
      @(negedge clk_i);
      while (done_o !== 1'b1 && k < 200) begin
         @(negedge clk_i);
         k++;
         if (k == 1) check({tag, "_busy_first"}, 64'(busy_o), 64'd1);
         if (pa > 0) start_i = (k == pa - 1) || (k == 2 * pa - 1);
      end
      if (pa > 0) start_i = 1'b0;
      check({tag, "_latency"}, 64'(k), 64'(exp_lat));
      check({tag, "_busy_done"}, 64'(busy_o), 64'd1);
   endtask

   task automatic post_done(input string tag);
      @(negedge clk_i);
      check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      check({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int ndone;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      a_i         = '0;
      b_i         = '0;
      operacion_i = 2'b00;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Reset values
      check("rst_busy",    64'(busy_o),     64'd0);
      check("rst_done",    64'(done_o),     64'd0);
      check("rst_hi",      64'(hi_o),       64'd0);
      check("rst_lo",      64'(lo_o),       64'd0);
      check("rst_divzero", 64'(divzero_o),  64'd0);
      check("rst_zf",      64'(zeroflag_o), 64'd1);

      // MULTU max x max = 0xFFFFFFFE_00000001
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_done("multu_max", 33, 0);
      check("multu_max_hi", 64'(hi_o), 64'hFFFF_FFFE);
      check("multu_max_lo", 64'(lo_o), 64'h0000_0001);
      post_done("multu_max");
      check("multu_max_hold", 64'(hi_o), 64'hFFFF_FFFE);

      // MULT -3 x 7 = -21
      launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
      wait_done("mult_neg", 33, 0);
      check("mult_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
      check("mult_neg_lo", 64'(lo_o), 64'hFFFF_FFEB);
      check("mult_neg_zf", 64'(zeroflag_o), 64'd0);
      post_done("mult_neg");

      // MULT -2^31 x 2 = -2^32
      launch(2'b00, 32'h8000_0000, 32'd2, 1'b0);
      wait_done("mult_min", 33, 0);
      check("mult_min_hi", 64'(hi_o), 64'hFFFF_FFFF);
      check("mult_min_lo", 64'(lo_o), 64'h0000_0000);
      check("mult_min_zf", 64'(zeroflag_o), 64'd1);
      post_done("mult_min");

      // Back-to-back: start held into the done cycle is accepted there
      launch(2'b01, 32'd6, 32'd7, 1'b1);
      wait_done("b2b_first", 33, 0);
      check("b2b_first_lo", 64'(lo_o), 64'd42);
      check("b2b_first_hi", 64'(hi_o), 64'd0);
      operacion_i = 2'b00;
      a_i         = 32'hFFFF_FFFB;   // -5
      b_i         = 32'hFFFF_FFFA;   // -6
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wait_done("b2b_second", 33, 0);
      check("b2b_second_lo", 64'(lo_o), 64'd30);
      check("b2b_second_hi", 64'(hi_o), 64'd0);
      post_done("b2b_second");

`ifdef MULTDIV_DIV_EN
      launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);   // -7 / 2
      wait_done("div_neg", 33, 0);
      check("div_neg_lo", 64'(lo_o), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
      post_done("div_neg");

      launch(2'b11, 32'd100, 32'd7, 1'b0);
      wait_done("divu", 33, 0);
      check("divu_lo", 64'(lo_o), 64'd14);
      check("divu_hi", 64'(hi_o), 64'd2);
      post_done("divu");

      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done("div_ovf", 33, 0);
      check("div_ovf_lo", 64'(lo_o), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi_o), 64'd0);
      post_done("div_ovf");

      launch(2'b11, 32'd5, 32'd0, 1'b0);
      wait_done("divzero", 1, 0);
      check("divzero_lo",   64'(lo_o), 64'hFFFF_FFFF);
      check("divzero_hi",   64'(hi_o), 64'd5);
      check("divzero_flag", 64'(divzero_o), 64'd1);
      post_done("divzero");
      check("divzero_held", 64'(divzero_o), 64'd1);

      launch(2'b01, 32'd0, 32'd9, 1'b0);
      wait_done("mul_zero", 33, 0);
      check("mul_zero_dz", 64'(divzero_o), 64'd0);
      check("mul_zero_lo", 64'(lo_o), 64'd0);
      check("mul_zero_zf", 64'(zeroflag_o), 64'd1);
      post_done("mul_zero");
`else
      launch(2'b10, 32'd10, 32'd3, 1'b0);
      wait_done("nodiv", 1, 0);
      check("nodiv_hi", 64'(hi_o), 64'd0);
      check("nodiv_lo", 64'(lo_o), 64'd0);
      check("nodiv_dz", 64'(divzero_o), 64'd0);
      check("nodiv_zf", 64'(zeroflag_o), 64'd1);
      post_done("nodiv");

      launch(2'b11, 32'd100, 32'd7, 1'b0);
      wait_done("nodivu", 1, 0);
      check("nodivu_lo", 64'(lo_o), 64'd0);
      post_done("nodivu");
`endif

      // start_i pulses at edges 5 and 10 while busy are ignored
      launch(2'b01, 32'd1000, 32'd1000, 1'b0);
      wait_done("ignore", 33, 5);
      check("ignore_lo", 64'(lo_o), 64'd1000000);
      check("ignore_hi", 64'(hi_o), 64'd0);
      post_done("ignore");

      // Reset asserted at edge 12 aborts the operation
      launch(2'b01, 32'd3, 32'd4, 1'b0);
      @(negedge clk_i);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_i);
         if (k == 11) rst_i = 1'b1;
      end
      check("abort_busy", 64'(busy_o), 64'd0);
      check("abort_hi",   64'(hi_o),   64'd0);
      check("abort_lo",   64'(lo_o),   64'd0);
      check("abort_zf",   64'(zeroflag_o), 64'd1);
      rst_i = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (done_o === 1'b1) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      check("abort_idle_busy", 64'(busy_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
